// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: mode encoding and duty width shared by the LED PWM controller
package pwm_ctrl_pkg;
  localparam int DUTY_W = 8;
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_STEP    = 2'd1,
    MODE_BRTH_UP = 2'd2,
    MODE_BRTH_DN = 2'd3
  } mode_t;
endpackage

// File: rtl/pwm_led_controller_btn_press_decoder.sv
// btn_press_decoder: sync + debounce of active-low btn into one-cycle short_evt/long_evt pulses (clk, rst_n, btn -> short_evt, long_evt)
module btn_press_decoder #(
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int LONG_CYCLES     = 27_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic short_evt,
  output logic long_evt
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  logic [1:0] sync;
  logic level, flip, pressed;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  assign pressed = !level;
  assign flip    = (sync[1] != level) && (deb_cnt == DEB_LAST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync      <= 2'b11;
      level     <= 1'b1;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      short_evt <= 1'b0;
      long_evt  <= 1'b0;
    end else begin
      sync      <= {sync[0], btn};
      deb_cnt   <= (sync[1] == level || flip) ? '0 : deb_cnt + 1'b1;
      level     <= flip ? sync[1] : level;
      hold_cnt  <= !pressed ? '0 : (hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + 1'b1);
      long_evt  <= pressed && hold_cnt == HOLD_LAST;
      short_evt <= flip && pressed && hold_cnt < HOLD_LAST;
    end
endmodule

// File: rtl/pwm_led_controller.sv
// pwm_led_controller: button-driven mode FSM + glitch-free PWM (clk, rst_n, btn -> led, duty, mode, period_start)
module pwm_led_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int PERIOD          = 100,
  parameter int STEP            = 25,
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int LONG_CYCLES     = 27_000_000,
  parameter int FADE_CYCLES     = 27_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn,
  output logic              led,
  output logic [DUTY_W-1:0] duty,
  output logic [1:0]        mode,
  output logic              period_start
);
  localparam int CW  = $clog2(PERIOD);
  localparam int FW  = $clog2(FADE_CYCLES + 1);
  localparam int W9  = DUTY_W + 1;
  localparam logic [CW-1:0]     CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [FW-1:0]     FADE_LAST = FW'(FADE_CYCLES - 1);
  localparam logic [W9-1:0]     P9        = W9'(PERIOD);
  localparam logic [W9-1:0]     S9        = W9'(STEP);
  localparam logic [DUTY_W-1:0] P8        = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] S8        = DUTY_W'(STEP);
  mode_t state, state_n;
  logic [DUTY_W-1:0] target, target_n, shadow;
  logic [CW-1:0] cnt;
  logic [FW-1:0] pre;
  logic short_evt, long_evt, breathing, tick;
  logic [W9-1:0] step_sum, up_sum;
  btn_press_decoder #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES)
  ) u_dec (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .short_evt(short_evt),
    .long_evt (long_evt)
  );
  assign breathing = state == MODE_BRTH_UP || state == MODE_BRTH_DN;
  assign tick      = breathing && pre == FADE_LAST;
  assign step_sum  = {1'b0, target} + S9;
  assign up_sum    = {1'b0, target} + 1'b1;
  // events take priority over fade ticks, so a coinciding tick is simply dropped
  always_comb begin
    state_n  = state;
    target_n = target;
    case (state)
      MODE_OFF:
        if (long_evt) begin
          state_n  = MODE_BRTH_UP;
          target_n = '0;
        end else if (short_evt) begin
          state_n  = MODE_STEP;
          target_n = S8;
        end
      MODE_STEP:
        if (long_evt) state_n = MODE_BRTH_UP;
        else if (short_evt) begin
          if ({1'b0, target} >= P9) begin
            state_n  = MODE_OFF;
            target_n = '0;
          end else target_n = step_sum > P9 ? P8 : step_sum[DUTY_W-1:0];
        end
      MODE_BRTH_UP:
        if (long_evt) begin
          state_n  = MODE_OFF;
          target_n = '0;
        end else if (tick) begin
          target_n = up_sum >= P9 ? P8 : up_sum[DUTY_W-1:0];
          if (up_sum >= P9) state_n = MODE_BRTH_DN;
        end
      default:
        if (long_evt) begin
          state_n  = MODE_OFF;
          target_n = '0;
        end else if (tick) begin
          target_n = target == '0 ? '0 : target - 1'b1;
          if (target <= DUTY_W'(1)) state_n = MODE_BRTH_UP;
        end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= MODE_OFF;
      target <= '0;
    end else begin
      state  <= state_n;
      target <= target_n;
    end
  // prescaler sits at 0 outside breathing, which is what clears it on entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre          <= '0;
      cnt          <= '0;
      shadow       <= '0;
      led          <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pre          <= (breathing && !tick) ? pre + 1'b1 : '0;
      cnt          <= cnt == CNT_LAST ? '0 : cnt + 1'b1;
      shadow       <= cnt == CNT_LAST ? target : shadow;
      period_start <= cnt == CNT_LAST;
      led          <= DUTY_W'(cnt) < shadow;
    end
  assign duty = shadow;
  assign mode = state;
endmodule
